// File: rtl/if_redirect_ctrl_pkg.sv
// if_redirect_ctrl_pkg: shared types and helpers for the fetch redirect controller
package if_redirect_ctrl_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, EXC, HALT} redir_state_t;

    typedef enum logic [2:0] {SRC_NONE, SRC_IX, SRC_ILL, SRC_RTI, SRC_HALT, SRC_JMP} redir_src_t;

    localparam logic [15:0] INST_BYTES = 16'd2;

    function automatic logic [15:0] seq_pc(input logic [15:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/if_redirect_ctrl_if.sv
// if_redirect_ctrl_if: decode/execute requests in, fetch redirect and status out
interface if_redirect_ctrl_if;
    logic [15:0] pc_id_p1;
    logic        halt_idif_p1;
    logic        nop_idif_p1;
    logic        illegal_op_idif_p1;
    logic        return_execution_idif_p1;
    logic        jmp_displacement_idif_p1;
    logic [15:0] jmp_displacement_value_idif_p1;
    logic        redirect_ix_p1;
    logic [15:0] redirect_target_ix_p1;
    logic [15:0] next_pc_p1;
    logic        pc_we_p1;
    logic        flush_ifid_p1;
    logic        fetch_stall_p1;
    logic [15:0] epc_p1;
    logic        halted_p1;
    logic        in_exception_p1;
    logic        err_p1;

    modport master (
        output pc_id_p1, halt_idif_p1, nop_idif_p1, illegal_op_idif_p1, return_execution_idif_p1,
               jmp_displacement_idif_p1, jmp_displacement_value_idif_p1, redirect_ix_p1, redirect_target_ix_p1,
        input  next_pc_p1, pc_we_p1, flush_ifid_p1, fetch_stall_p1, epc_p1, halted_p1, in_exception_p1, err_p1
    );

    modport slave (
        input  pc_id_p1, halt_idif_p1, nop_idif_p1, illegal_op_idif_p1, return_execution_idif_p1,
               jmp_displacement_idif_p1, jmp_displacement_value_idif_p1, redirect_ix_p1, redirect_target_ix_p1,
        output next_pc_p1, pc_we_p1, flush_ifid_p1, fetch_stall_p1, epc_p1, halted_p1, in_exception_p1, err_p1
    );
endinterface

// File: rtl/if_redirect_ctrl_arb.sv
// redirect_arb: picks the oldest pending request and its redirect target
module redirect_arb
    import if_redirect_ctrl_pkg::*;
#(
    parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
    input  logic        decode_en,
    input  logic        ix,
    input  logic [15:0] ix_target,
    input  logic        ill,
    input  logic        rti,
    input  logic        halt,
    input  logic        jmp,
    input  logic [15:0] disp,
    input  logic [15:0] pc_id,
    input  logic [15:0] epc,
    output logic        valid,
    output redir_src_t  src,
    output logic [15:0] target
);

    // Execute is older than decode, so it wins even when decode is masked
    always_comb begin
        src = ix ? SRC_IX : !decode_en ? SRC_NONE : ill ? SRC_ILL : rti ? SRC_RTI :
              halt ? SRC_HALT : jmp ? SRC_JMP : SRC_NONE;
        target = src == SRC_IX  ? ix_target :
                 src == SRC_ILL ? EXC_VECTOR :
                 src == SRC_RTI ? epc :
                 src == SRC_JMP ? seq_pc(pc_id) + disp : 16'h0000;
        valid = src != SRC_NONE;
    end

endmodule

// File: rtl/if_redirect_ctrl.sv
// if_redirect_ctrl: turns decode/execute control requests into registered fetch redirects
module if_redirect_ctrl
    import if_redirect_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] EXC_VECTOR   = 16'h0002,
    parameter int          FLUSH_CYCLES = 1
) (
    input logic               clk,
    input logic               rst,
    if_redirect_ctrl_if.slave bus
);

    redir_state_t state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [15:0]  next_pc_q, next_pc_d;
    logic [15:0]  epc_q, epc_d;
    logic         pc_we_q, pc_we_d;
    logic         in_exc_q, in_exc_d;
    logic         err_q, err_d;
    logic         redirect;
    logic         arb_valid;
    redir_src_t   arb_src;
    logic [15:0]  arb_target;

    redirect_arb #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
        .decode_en (state_q == RUN || state_q == EXC),
        .ix        (bus.redirect_ix_p1),
        .ix_target (bus.redirect_target_ix_p1),
        .ill       (bus.illegal_op_idif_p1),
        .rti       (bus.return_execution_idif_p1),
        .halt      (bus.halt_idif_p1),
        .jmp       (bus.jmp_displacement_idif_p1),
        .disp      (bus.jmp_displacement_value_idif_p1),
        .pc_id     (bus.pc_id_p1),
        .epc       (epc_q),
        .valid     (arb_valid),
        .src       (arb_src),
        .target    (arb_target)
    );

    // Next state: flush countdown, then act on the arbitrated request; HALT freezes everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        next_pc_d = next_pc_q;
        epc_d     = epc_q;
        pc_we_d   = 1'b0;
        in_exc_d  = in_exc_q;
        err_d     = err_q;
        redirect  = 1'b0;
        if (state_q != HALT) begin
            if (state_q == FLUSH) begin
                if (cnt_q == 2'd0) state_d = in_exc_q ? EXC : RUN;
                else cnt_d = cnt_q - 2'd1;
            end
            if (arb_valid) begin
                if (arb_src == SRC_ILL && in_exc_q) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else if (arb_src == SRC_ILL) begin
                    epc_d    = seq_pc(bus.pc_id_p1);
                    in_exc_d = 1'b1;
                    redirect = 1'b1;
                end else if (arb_src == SRC_RTI && !in_exc_q) begin
                    err_d = 1'b1;
                end else if (arb_src == SRC_RTI) begin
                    in_exc_d = 1'b0;
                    redirect = 1'b1;
                end else if (arb_src == SRC_HALT) begin
                    state_d = HALT;
                end else begin
                    redirect = 1'b1;
                end
            end
            if (redirect) begin
                next_pc_d = arb_target;
                pc_we_d   = 1'b1;
                state_d   = FLUSH;
                cnt_d     = 2'(FLUSH_CYCLES - 1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 2'd0;
            next_pc_q <= RESET_PC;
            epc_q     <= 16'h0000;
            pc_we_q   <= 1'b0;
            in_exc_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            next_pc_q <= next_pc_d;
            epc_q     <= epc_d;
            pc_we_q   <= pc_we_d;
            in_exc_q  <= in_exc_d;
            err_q     <= err_d;
        end
    end

    assign bus.next_pc_p1      = next_pc_q;
    assign bus.pc_we_p1        = pc_we_q;
    assign bus.flush_ifid_p1   = state_q == FLUSH;
    assign bus.fetch_stall_p1  = state_q == HALT;
    assign bus.halted_p1       = state_q == HALT;
    assign bus.epc_p1          = epc_q;
    assign bus.in_exception_p1 = in_exc_q;
    assign bus.err_p1          = err_q;

endmodule

// File: tb/tb_if_redirect_ctrl.sv
// tb_if_redirect_ctrl: directed + random stimulus against a behavioural model with a scoreboard queue
module tb_if_redirect_ctrl;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] EXC_VEC  = 16'h0002;
    localparam int          FC       = 2;

    typedef struct {
        logic [15:0] npc;
        logic [15:0] epc;
        logic        we;
        logic        fl;
        logic        st;
        logic        hl;
        logic        ex;
        logic        er;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    exp_t sb[$];

    logic        m_halt, m_exc, m_err, m_we;
    int          m_fl;
    logic [15:0] m_epc, m_npc;

    if_redirect_ctrl_if bus();

    if_redirect_ctrl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VEC), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s actual=%h required=%h", n, a, e);
    endtask

    // Applies one cycle of inputs and predicts the outputs visible after the next rising edge
    task automatic step(input logic r, input logic [15:0] pc, input logic h, input logic n, input logic il,
                        input logic rt, input logic jm, input logic [15:0] d, input logic ix,
                        input logic [15:0] t);
        logic [15:0] tgt;
        logic        go;
        @(negedge clk);
        #1;
        rst = r;
        bus.pc_id_p1 = pc;
        bus.halt_idif_p1 = h;
        bus.nop_idif_p1 = n;
        bus.illegal_op_idif_p1 = il;
        bus.return_execution_idif_p1 = rt;
        bus.jmp_displacement_idif_p1 = jm;
        bus.jmp_displacement_value_idif_p1 = d;
        bus.redirect_ix_p1 = ix;
        bus.redirect_target_ix_p1 = t;
        tgt = 16'h0000;
        go = 1'b0;
        m_we = 1'b0;
        if (r) begin
            m_halt = 0; m_exc = 0; m_err = 0; m_fl = 0; m_epc = 16'h0000; m_npc = RESET_PC;
        end else if (!m_halt) begin
            if (ix) begin
                go = 1; tgt = t;
            end else if (m_fl == 0) begin
                if (il) begin
                    if (m_exc) begin m_err = 1; m_halt = 1; end
                    else begin m_epc = pc + 16'd2; m_exc = 1; go = 1; tgt = EXC_VEC; end
                end else if (rt) begin
                    if (m_exc) begin m_exc = 0; go = 1; tgt = m_epc; end
                    else m_err = 1;
                end else if (h) m_halt = 1;
                else if (jm) begin go = 1; tgt = pc + 16'd2 + d; end
            end
            if (go) begin m_npc = tgt; m_we = 1; m_fl = FC; end
            else if (m_fl > 0) m_fl--;
        end
        sb.push_back('{m_npc, m_epc, m_we, m_fl > 0, m_halt, m_halt, m_exc, m_err});
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    endtask

    task automatic rnd(input int n, input int rst_odds);
        repeat (n) step($urandom_range(0, rst_odds - 1) == 0, 16'($urandom), $urandom_range(0, 31) == 0,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                        $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 7) == 0, 16'($urandom));
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the oldest prediction
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("next_pc", bus.next_pc_p1, e.npc);
            chk("epc", bus.epc_p1, e.epc);
            chk("pc_we", 16'(bus.pc_we_p1), 16'(e.we));
            chk("flush", 16'(bus.flush_ifid_p1), 16'(e.fl));
            chk("stall", 16'(bus.fetch_stall_p1), 16'(e.st));
            chk("halted", 16'(bus.halted_p1), 16'(e.hl));
            chk("in_exc", 16'(bus.in_exception_p1), 16'(e.ex));
            chk("err", 16'(bus.err_p1), 16'(e.er));
        end
    end

    initial begin
        bus.pc_id_p1 = 0; bus.halt_idif_p1 = 0; bus.nop_idif_p1 = 0; bus.illegal_op_idif_p1 = 0;
        bus.return_execution_idif_p1 = 0; bus.jmp_displacement_idif_p1 = 0;
        bus.jmp_displacement_value_idif_p1 = 0; bus.redirect_ix_p1 = 0; bus.redirect_target_ix_p1 = 0;
        step(1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        step(1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        step(0, 16'h0040, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
        idle(3);
        step(0, 16'h0002, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        idle(3);
        step(0, 16'h0050, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        idle(1);
        step(1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        step(0, 16'h0060, 1, 0, 1, 0, 0, 16'h0000, 1, 16'h1234);
        idle(3);
        step(0, 16'hFFFE, 0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000);
        idle(3);
        step(0, 16'h0010, 0, 0, 0, 0, 1, 16'hFFF0, 0, 16'h0000);
        idle(3);
        step(0, 16'h0020, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        step(0, 16'h0022, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        rnd(20, 1 << 30);
        step(1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        idle(2);
        step(0, 16'h0040, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
        idle(3);
        step(0, 16'h0004, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
        idle(2);
        step(1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        step(0, 16'h0100, 0, 0, 0, 0, 1, 16'h0004, 0, 16'h0000);
        step(0, 16'h0102, 0, 0, 0, 0, 1, 16'h0100, 0, 16'h0000);
        step(0, 16'h0104, 0, 0, 1, 0, 0, 16'h0000, 1, 16'h5555);
        step(0, 16'h0106, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        idle(4);
        rnd(3000, 20);
        @(posedge clk);
        #2;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain actual=%0d required=0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
